lspc2_vram_slot_sched: RTL and testbench
========================================

// Module: lspc2_vram_slot_sched
// PURPOSE
//  Free-running 16-phase sequencer at 24 MHz. Emits one-cycle clock-enable strobes aligned to the
//  LSPC 12/6/3/1.5 MHz divider phases, and divides each 1.5 MHz period into four 4-tick VRAM slots.
//  Each slot is granted to either the video fetch path or the CPU (68k VRAM port) and drives the
//  shared VRAM address, data and write-enable lines. Sits between the LSPC clock divider and VRAM.
// PARAMETERS
//  CPU_STEAL  1  1: CPU may use slots 0-2 while VIDEO_REQ=0; 0: CPU is restricted to slot 3
//  AW         16 VRAM address width
//  DW         16 VRAM data width
// PORTS
//  CLK_24M         in  1   master clock; all state updates on the rising edge
//  nRESET          in  1   asynchronous, active-low reset
//  PHASE           out 4   phase counter, 0..15, wraps to 0
//  CE_12M          out 1   high when PHASE[0]=1
//  CE_6M           out 1   high when PHASE[1:0]=3
//  CE_3M           out 1   high when PHASE[2:0]=7
//  CE_1_5M         out 1   high when PHASE=15
//  VIDEO_REQ       in  1   video path requests slots 0-2 (active display/fetch window)
//  VID_ADDR        in  AW  video fetch address
//  VID_RDATA_VALID out 1   1-cycle pulse: CPU_RDATA/VRAM data from a video slot is valid (same data bus)
//  CPU_REQ         in  1   level request; hold until CPU_ACK
//  CPU_WE          in  1   1 = write, 0 = read
//  CPU_ADDR        in  AW  CPU address
//  CPU_WDATA       in  DW  CPU write data
//  CPU_ACK         out 1   1-cycle completion pulse
//  CPU_RDATA       out DW  read data, registered at slot end (also carries video read data)
//  VRAM_ADDR       out AW  registered VRAM address
//  VRAM_WDATA      out DW  registered VRAM write data
//  VRAM_WE         out 1   VRAM write enable, active high
//  VRAM_RDATA      in  DW  VRAM read data
//  SLOT_OWNER      out 2   0 = idle, 1 = video, 2 = CPU
// BEHAVIOUR
//  - Reset (async): PHASE=0, SLOT_OWNER=0, VRAM_WE=0, VRAM_ADDR=0, VRAM_WDATA=0, CPU_RDATA=0,
//    CPU_ACK=0, VID_RDATA_VALID=0, arm flag=1. The CE_* outputs are decoded from PHASE, so all are 0
//    at reset. A reset in mid-slot aborts the access: no ACK is issued and the request must be re-presented.
//  - PHASE increments by 1 every cycle. Slot s (0..3) occupies PHASE 4s..4s+3.
//  - Grant is decided on the edge PHASE 4s-1 -> 4s, using the inputs sampled on that edge.
//    - Slots 0-2: video if VIDEO_REQ=1; otherwise CPU if the request is eligible and CPU_STEAL=1;
//      otherwise idle.
//    - Slot 3: CPU if the request is eligible, otherwise idle. Video never owns slot 3.
//    - A CPU request is eligible when CPU_REQ=1 and the arm flag is 1.
//  - On grant, VRAM_ADDR is loaded with VID_ADDR or CPU_ADDR. For a CPU write, CPU_WDATA is also
//    latched into VRAM_WDATA. VRAM_ADDR keeps its value through idle slots.
//  - VRAM_WE=1 only during PHASE 4s+1 and 4s+2 of a CPU write slot. It is low during the tick where
//    the address changes.
//  - On the edge that ends PHASE 4s+3:
//    - CPU read slot: CPU_RDATA <= VRAM_RDATA.
//    - Video slot: CPU_RDATA <= VRAM_RDATA and VID_RDATA_VALID pulses.
//    - CPU slot (read or write): CPU_ACK pulses.
//    The pulse is visible during PHASE 4s+4 mod 16, so latency is 4 cycles from the grant edge.
//  - Arm flag: cleared when a CPU grant is made; set again when CPU_REQ is sampled 0. A CPU_REQ held
//    high past ACK produces no second access.
//  - Simultaneous events:
//    - VIDEO_REQ wins slots 0-2 over the CPU.
//    - A VIDEO_REQ change mid-slot does not affect the current owner.
//    - CPU input changes after the grant edge are ignored for the current slot.
//  - Worst-case CPU wait, with VIDEO_REQ=1: 16 cycles plus 4 cycles of access.
// TESTING
//  1. Release reset and run 32 cycles -> PHASE 0..15 twice; CE_6M at PHASE 3/7/11/15; CE_1_5M once
//     per 16; CE_12M on odd phases.
//  2. VIDEO_REQ=1, CPU read 0x8000 with REQ rising during PHASE 1, VRAM_RDATA=0x1234 -> SLOT_OWNER=2
//     at PHASE 12-15; VRAM_ADDR=0x8000; CPU_ACK=1 and CPU_RDATA=0x1234 during PHASE 0.
//  3. VIDEO_REQ=0, CPU write 0x0100<=0xBEEF with REQ during PHASE 2 -> slot 1 granted; VRAM_WE=1
//     only at PHASE 5,6; VRAM_WDATA=0xBEEF; CPU_ACK during PHASE 8.
//  4. CPU_REQ held high for 48 cycles after ACK -> exactly one access; drop REQ for 1 cycle, then
//     re-assert -> second access at the next eligible slot.
//  5. Assert nRESET during PHASE 5 of the CPU write in test 3 -> VRAM_WE falls immediately with no
//     clock edge; all outputs at reset values; no CPU_ACK after release.
//  6. VIDEO_REQ=1, CPU_REQ=0 -> SLOT_OWNER sequence 1,1,1,0 per period; VID_RDATA_VALID at PHASE
//     4, 8 and 12; VRAM_WE never 1.

Source files
------------

// File: rtl/lspc2_vram_slot_sched.sv
// lspc2_vram_slot_sched
//   Free-running 16-phase sequencer on the 24 MHz master clock. It decodes
//   the 12/6/3/1.5 MHz clock-enable strobes from the phase counter. It also
//   splits each 1.5 MHz period into four 4-tick VRAM slots, and each slot is
//   owned by the video fetch path, by the 68k CPU port, or by nobody.
//
// Ports
//   CLK_24M, nRESET        master clock, asynchronous active-low reset
//   PHASE, CE_*            phase counter and decoded clock-enable strobes
//   VIDEO_REQ, VID_ADDR    video fetch request (slots 0-2) and address
//   VID_RDATA_VALID        one-cycle pulse: CPU_RDATA holds video read data
//   CPU_REQ/WE/ADDR/WDATA  CPU level request, held until CPU_ACK
//   CPU_ACK, CPU_RDATA     completion pulse and read data, registered at slot end
//   VRAM_ADDR/WDATA/WE     registered VRAM drive
//   VRAM_RDATA             VRAM read data, sampled at slot end
//   SLOT_OWNER             0 idle, 1 video, 2 CPU
//
// Slot owner states
//   OWN_IDLE | no access this slot, VRAM_ADDR holds its last value
//   OWN_VID  | video fetch, data returned with VID_RDATA_VALID
//   OWN_CPU  | CPU access, CPU_ACK at slot end
module lspc2_vram_slot_sched #(
  parameter bit CPU_STEAL = 1'b1,
  parameter int AW        = 16,
  parameter int DW        = 16
) (
  input  logic          CLK_24M,
  input  logic          nRESET,
  output logic [3:0]    PHASE,
  output logic          CE_12M,
  output logic          CE_6M,
  output logic          CE_3M,
  output logic          CE_1_5M,
  input  logic          VIDEO_REQ,
  input  logic [AW-1:0] VID_ADDR,
  output logic          VID_RDATA_VALID,
  input  logic          CPU_REQ,
  input  logic          CPU_WE,
  input  logic [AW-1:0] CPU_ADDR,
  input  logic [DW-1:0] CPU_WDATA,
  output logic          CPU_ACK,
  output logic [DW-1:0] CPU_RDATA,
  output logic [AW-1:0] VRAM_ADDR,
  output logic [DW-1:0] VRAM_WDATA,
  output logic          VRAM_WE,
  input  logic [DW-1:0] VRAM_RDATA,
  output logic [1:0]    SLOT_OWNER
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  owner_t     owner_q;
  owner_t     owner_next;
  logic       cpu_wr_q;
  logic       arm_q;
  logic [1:0] next_slot;
  logic       cpu_elig;

  assign CE_12M     = PHASE[0];
  assign CE_6M      = &PHASE[1:0];
  assign CE_3M      = &PHASE[2:0];
  assign CE_1_5M    = &PHASE;
  assign SLOT_OWNER = owner_q;

  // Arbitration looks ahead to the slot that starts on the coming edge.
  // The arm flag stops a request that is still held after its ACK from
  // starting a second access.
  always_comb begin
    next_slot  = PHASE[3:2] + 2'd1;
    cpu_elig   = CPU_REQ & arm_q;
    owner_next = OWN_IDLE;
    if ((next_slot != 2'd3) && VIDEO_REQ)
      owner_next = OWN_VID;
    else if (cpu_elig && ((next_slot == 2'd3) || CPU_STEAL))
      owner_next = OWN_CPU;
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      PHASE           <= 4'd0;
      owner_q         <= OWN_IDLE;
      cpu_wr_q        <= 1'b0;
      arm_q           <= 1'b1;
      VRAM_WE         <= 1'b0;
      VRAM_ADDR       <= '0;
      VRAM_WDATA      <= '0;
      CPU_RDATA       <= '0;
      CPU_ACK         <= 1'b0;
      VID_RDATA_VALID <= 1'b0;
    end else begin
      PHASE           <= PHASE + 4'd1;
      CPU_ACK         <= 1'b0;
      VID_RDATA_VALID <= 1'b0;
      if (!CPU_REQ)
        arm_q <= 1'b1;

      case (PHASE[1:0])
        // Write strobe covers ticks 1 and 2 only, so the address is stable
        // on both sides of it.
        2'd0: VRAM_WE <= (owner_q == OWN_CPU) && cpu_wr_q;
        2'd2: VRAM_WE <= 1'b0;
        2'd3: begin
          // Close the slot that is ending.
          if (owner_q == OWN_CPU) begin
            CPU_ACK <= 1'b1;
            if (!cpu_wr_q)
              CPU_RDATA <= VRAM_RDATA;
          end else if (owner_q == OWN_VID) begin
            CPU_RDATA       <= VRAM_RDATA;
            VID_RDATA_VALID <= 1'b1;
          end

          // Open the next slot.
          owner_q <= owner_next;
          VRAM_WE <= 1'b0;
          if (owner_next == OWN_VID) begin
            VRAM_ADDR <= VID_ADDR;
            cpu_wr_q  <= 1'b0;
          end else if (owner_next == OWN_CPU) begin
            VRAM_ADDR <= CPU_ADDR;
            cpu_wr_q  <= CPU_WE;
            arm_q     <= 1'b0;
            if (CPU_WE)
              VRAM_WDATA <= CPU_WDATA;
          end else begin
            cpu_wr_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lspc2_vram_slot_sched.sv
module tb_lspc2_vram_slot_sched;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    phase;
  logic          ce_12m, ce_6m, ce_3m, ce_1_5m;
  logic          video_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic          vid_valid;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;
  logic [AW-1:0] vram_addr;
  logic [DW-1:0] vram_wdata;
  logic          vram_we;
  logic [DW-1:0] vram_rdata = '0;
  logic [1:0]    slot_owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lspc2_vram_slot_sched #(.CPU_STEAL(1'b1), .AW(AW), .DW(DW)) dut (
    .CLK_24M(clk), .nRESET(rst_n), .PHASE(phase),
    .CE_12M(ce_12m), .CE_6M(ce_6m), .CE_3M(ce_3m), .CE_1_5M(ce_1_5m),
    .VIDEO_REQ(video_req), .VID_ADDR(vid_addr), .VID_RDATA_VALID(vid_valid),
    .CPU_REQ(cpu_req), .CPU_WE(cpu_we), .CPU_ADDR(cpu_addr), .CPU_WDATA(cpu_wdata),
    .CPU_ACK(cpu_ack), .CPU_RDATA(cpu_rdata), .VRAM_ADDR(vram_addr),
    .VRAM_WDATA(vram_wdata), .VRAM_WE(vram_we), .VRAM_RDATA(vram_rdata),
    .SLOT_OWNER(slot_owner)
  );

  // Reference model: tracked per tick in plain integers.
  int          m_phase;
  int          m_owner;
  bit          m_write;
  bit          m_arm;
  bit          m_ack, m_vv, m_we;
  int unsigned m_addr, m_wdata, m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_write = 0; m_arm = 1;
    m_ack = 0; m_vv = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_rdata = 0;
  endtask

  task automatic model_tick();
    int np, s;
    np = (m_phase + 1) % 16;
    m_ack = 0;
    m_vv  = 0;
    if (m_phase % 4 == 3) begin
      if (m_owner == 2) begin
        m_ack = 1;
        if (!m_write) m_rdata = vram_rdata;
      end else if (m_owner == 1) begin
        m_rdata = vram_rdata;
        m_vv    = 1;
      end
      s = np / 4;
      if (s < 3 && video_req) begin
        m_owner = 1; m_write = 0; m_addr = vid_addr;
      end else if (cpu_req && m_arm) begin
        m_owner = 2; m_write = cpu_we; m_addr = cpu_addr; m_arm = 0;
        if (cpu_we) m_wdata = cpu_wdata;
      end else begin
        m_owner = 0; m_write = 0;
      end
    end
    if (!cpu_req) m_arm = 1;
    m_we = (m_owner == 2) && m_write && (np % 4 == 1 || np % 4 == 2);
    m_phase = np;
  endtask

  task automatic compare_all();
    chk("phase", 32'(phase), 32'(m_phase));
    chk("ce_12m", 32'(ce_12m), 32'(m_phase % 2 == 1));
    chk("ce_6m", 32'(ce_6m), 32'(m_phase % 4 == 3));
    chk("ce_3m", 32'(ce_3m), 32'(m_phase % 8 == 7));
    chk("ce_1_5m", 32'(ce_1_5m), 32'(m_phase == 15));
    chk("slot_owner", 32'(slot_owner), 32'(m_owner));
    chk("vram_addr", 32'(vram_addr), m_addr);
    chk("vram_wdata", 32'(vram_wdata), m_wdata);
    chk("vram_we", 32'(vram_we), 32'(m_we));
    chk("cpu_ack", 32'(cpu_ack), 32'(m_ack));
    chk("cpu_rdata", 32'(cpu_rdata), m_rdata);
    chk("vid_valid", 32'(vid_valid), 32'(m_vv));
  endtask

  int n_ack, n_vv, n_we, n_ce12, n_ce6, n_ce15;
  int we_mask;
  bit rnd_rdata = 1'b1;

  // One clock: model consumes the inputs the DUT samples on this edge, then
  // outputs are compared 1 time unit after the edge.
  task automatic step();
    model_tick();
    @(posedge clk);
    #1;
    compare_all();
    if (cpu_ack) n_ack++;
    if (vid_valid) n_vv++;
    if (vram_we) begin n_we++; we_mask |= (1 << m_phase); end
    if (ce_12m) n_ce12++;
    if (ce_6m) n_ce6++;
    if (ce_1_5m) n_ce15++;
    vid_addr = AW'($urandom);
    if (rnd_rdata) vram_rdata = DW'($urandom);
  endtask

  task automatic run_to(input int p);
    for (int i = 0; i < 40 && m_phase != p; i++) step();
    chk("run_to_phase", 32'(m_phase), 32'(p));
  endtask

  task automatic clear_counts();
    n_ack = 0; n_vv = 0; n_we = 0; n_ce12 = 0; n_ce6 = 0; n_ce15 = 0; we_mask = 0;
  endtask

  initial begin
    model_reset();
    clear_counts();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all();

    // 1: free-running phase and strobes
    for (int i = 0; i < 32; i++) step();
    chk("t1_ce12_count", 32'(n_ce12), 32'd16);
    chk("t1_ce6_count", 32'(n_ce6), 32'd8);
    chk("t1_ce15_count", 32'(n_ce15), 32'd2);

    // 2: CPU read confined to slot 3 while video is active
    video_req = 1'b1;
    run_to(1);
    rnd_rdata = 1'b0;
    vram_rdata = 16'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
    run_to(12);
    chk("t2_owner", 32'(slot_owner), 32'd2);
    chk("t2_addr", 32'(vram_addr), 32'h8000);
    run_to(0);
    chk("t2_ack", 32'(cpu_ack), 32'd1);
    chk("t2_rdata", 32'(cpu_rdata), 32'h1234);
    cpu_req = 1'b0;
    rnd_rdata = 1'b1;

    // 3: CPU write steals slot 1
    video_req = 1'b0;
    run_to(2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
    clear_counts();
    run_to(8);
    chk("t3_ack", 32'(cpu_ack), 32'd1);
    chk("t3_we_phases", 32'(we_mask), 32'h0060);
    chk("t3_wdata", 32'(vram_wdata), 32'hBEEF);
    cpu_req = 1'b0;

    // 4: held request yields one access; a one-cycle drop re-arms it
    video_req = 1'b1;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4242;
    clear_counts();
    for (int i = 0; i < 64; i++) step();
    chk("t4_single_access", 32'(n_ack), 32'd1);
    cpu_req = 1'b0;
    step();
    cpu_req = 1'b1;
    clear_counts();
    for (int i = 0; i < 21; i++) step();
    chk("t4_second_access", 32'(n_ack), 32'd1);
    cpu_req = 1'b0;
    step();

    // 5: asynchronous reset in the middle of a write slot
    video_req = 1'b0;
    run_to(2);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0100; cpu_wdata = 16'hBEEF;
    run_to(5);
    chk("t5_we_before_reset", 32'(vram_we), 32'd1);
    cpu_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_we_async", 32'(vram_we), 32'd0);
    chk("t5_phase", 32'(phase), 32'd0);
    chk("t5_owner", 32'(slot_owner), 32'd0);
    chk("t5_addr", 32'(vram_addr), 32'd0);
    chk("t5_wdata", 32'(vram_wdata), 32'd0);
    chk("t5_rdata", 32'(cpu_rdata), 32'd0);
    chk("t5_ack", 32'(cpu_ack), 32'd0);
    chk("t5_vv", 32'(vid_valid), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    compare_all();
    clear_counts();
    for (int i = 0; i < 20; i++) step();
    chk("t5_no_ack_after_reset", 32'(n_ack), 32'd0);

    // 6: video only
    video_req = 1'b1;
    run_to(15);
    step();
    clear_counts();
    for (int i = 0; i < 32; i++) begin
      step();
      if (m_phase % 4 == 0)
        chk("t6_owner_seq", 32'(slot_owner), (m_phase == 12) ? 32'd0 : 32'd1);
    end
    chk("t6_vv_count", 32'(n_vv), 32'd6);
    chk("t6_no_we", 32'(n_we), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) video_req = ~video_req;
      if ($urandom_range(0, 3) == 0) cpu_req = ~cpu_req;
      cpu_we    = 1'($urandom);
      cpu_addr  = AW'($urandom);
      cpu_wdata = DW'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
